rename_stage: RTL

Four-wide register rename stage in the backend, between decode and the ROB/dispatch. It consumes free physical registers from the free register list (FRL) through the FRL's acquire mask handshake. It translates architectural source and destination registers through a speculative register alias table (RAT), with intra-group dependency forwarding. It keeps a committed RAT (CRAT) that restores the speculative map on a pipeline flush.

---
 rtl/rename_stage.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rename_stage.sv
// Four-wide register rename stage.
// Allocates destinations from the free register list, translates sources
// through the speculative RAT with in-group forwarding, and keeps a committed
// RAT that restores the speculative map on flush.

package reg_pkg;
    localparam int NUM_PHYS_REGS = 64;
endpackage

module rename_stage #(
    parameter int NUM_ARCH_REGS = 32,
    parameter int NUM_PHYS_REGS = reg_pkg::NUM_PHYS_REGS,
    parameter int WIDTH         = 4,
    localparam int PW           = $clog2(NUM_PHYS_REGS),
    localparam int AW           = $clog2(NUM_ARCH_REGS)
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [WIDTH-1:0]          dec_valid_in,
    input  logic [WIDTH-1:0]          dec_has_dest_in,
    input  logic [WIDTH-1:0][AW-1:0]  dec_rd_in,
    input  logic [WIDTH-1:0][AW-1:0]  dec_rs1_in,
    input  logic [WIDTH-1:0][AW-1:0]  dec_rs2_in,
    output logic                      dec_ready_out,

    input  logic                      frl_valid_in,
    input  logic [WIDTH-1:0][PW-1:0]  frl_regs_in,
    output logic [WIDTH-1:0]          frl_ready_out,

    output logic [WIDTH-1:0]          ren_valid_out,
    input  logic                      ren_ready_in,
    output logic [WIDTH-1:0][PW-1:0]  ren_prd_out,
    output logic [WIDTH-1:0][PW-1:0]  ren_old_prd_out,
    output logic [WIDTH-1:0][PW-1:0]  ren_prs1_out,
    output logic [WIDTH-1:0][PW-1:0]  ren_prs2_out,
    output logic [WIDTH-1:0]          ren_has_dest_out,

    input  logic [WIDTH-1:0]          commit_valid_in,
    input  logic [WIDTH-1:0][AW-1:0]  commit_rd_in,
    input  logic [WIDTH-1:0][PW-1:0]  commit_prd_in,

    input  logic                      flush_in
);

    logic [PW-1:0] rat       [NUM_ARCH_REGS];
    logic [PW-1:0] crat      [NUM_ARCH_REGS];
    logic [PW-1:0] rat_next  [NUM_ARCH_REGS];
    logic [PW-1:0] crat_next [NUM_ARCH_REGS];

    logic [WIDTH-1:0]         writes;
    logic [2:0]               need;
    logic [WIDTH-1:0]         acq_mask;
    logic                     stage_free;
    logic                     accept;
    logic [WIDTH-1:0][PW-1:0] prd_c;
    logic [WIDTH-1:0][PW-1:0] old_c;
    logic [WIDTH-1:0][PW-1:0] prs1_c;
    logic [WIDTH-1:0][PW-1:0] prs2_c;

    assign writes     = dec_valid_in & dec_has_dest_in;
    assign stage_free = (ren_valid_out == '0) || ren_ready_in;

    assign dec_ready_out = stage_free && !flush_in && (frl_valid_in || (need == 3'd0));
    assign accept        = dec_ready_out && (dec_valid_in != '0);
    // The acquire mask must stay quiet while reset is held, whatever decode offers.
    assign frl_ready_out = (accept && !rst) ? acq_mask : '0;

    // Hand out free registers in slot order; need ends as the total taken.
    always_comb begin
        need = 3'd0;
        for (int i = 0; i < WIDTH; i++) begin
            prd_c[i] = '0;
            if (writes[i]) begin
                prd_c[i] = frl_regs_in[need[1:0]];
            end
            need = need + {2'b00, writes[i]};
        end
    end

    // Contiguous acquire prefix covering the registers consumed.
    always_comb begin
        case (need)
            3'd1:    acq_mask = 4'b0001;
            3'd2:    acq_mask = 4'b0011;
            3'd3:    acq_mask = 4'b0111;
            3'd4:    acq_mask = 4'b1111;
            default: acq_mask = 4'b0000;
        endcase
    end

    // RAT lookup with forwarding; later older writers overwrite earlier ones, so the youngest wins.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            prs1_c[i] = rat[dec_rs1_in[i]];
            prs2_c[i] = rat[dec_rs2_in[i]];
            old_c[i]  = rat[dec_rd_in[i]];
            for (int j = 0; j < WIDTH; j++) begin
                if ((j < i) && writes[j]) begin
                    if (dec_rd_in[j] == dec_rs1_in[i]) prs1_c[i] = prd_c[j];
                    if (dec_rd_in[j] == dec_rs2_in[i]) prs2_c[i] = prd_c[j];
                    if (dec_rd_in[j] == dec_rd_in[i])  old_c[i]  = prd_c[j];
                end
            end
            if (!writes[i]) begin
                old_c[i] = '0;
            end
        end
    end

    // Committed map: retiring slots applied in program order.
    always_comb begin
        crat_next = crat;
        for (int k = 0; k < WIDTH; k++) begin
            if (commit_valid_in[k]) begin
                crat_next[commit_rd_in[k]] = commit_prd_in[k];
            end
        end
    end

    // Speculative map: flush restores the committed map (with this cycle's commits), else accept writes.
    always_comb begin
        rat_next = rat;
        if (flush_in) begin
            rat_next = crat_next;
        end else if (accept) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (writes[j]) begin
                    rat_next[dec_rd_in[j]] = prd_c[j];
                end
            end
        end
    end

    // Map tables, identity after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                rat[i]  <= PW'(i);
                crat[i] <= PW'(i);
            end
        end else begin
            rat  <= rat_next;
            crat <= crat_next;
        end
    end

    // Output pipeline register: load on accept, drain when consumed, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ren_valid_out    <= '0;
            ren_prd_out      <= '0;
            ren_old_prd_out  <= '0;
            ren_prs1_out     <= '0;
            ren_prs2_out     <= '0;
            ren_has_dest_out <= '0;
        end else if (flush_in) begin
            ren_valid_out <= '0;
        end else if (accept) begin
            ren_valid_out    <= dec_valid_in;
            ren_prd_out      <= prd_c;
            ren_old_prd_out  <= old_c;
            ren_prs1_out     <= prs1_c;
            ren_prs2_out     <= prs2_c;
            ren_has_dest_out <= dec_has_dest_in;
        end else if (ren_ready_in) begin
            ren_valid_out <= '0;
        end
    end

endmodule
